conv_window_sequencer: RTL and testbench

// Sequences the 3x3 convolution datapath: on start, walks every valid output pixel of an
// IMG_ROWS x IMG_COLS image held in the data region (0x80), issues coefficient (0x40) and

---
 rtl/conv_window_sequencer_pkg.sv | 30 +++
 rtl/conv_window_sequencer_addr_gen.sv | 79 +++++++
 rtl/conv_window_sequencer.sv | 128 ++++++++++++
 tb/tb_conv_window_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_sequencer_pkg.sv
// Shared definitions for the convolution window sequencer: address regions,
// route codes, filter geometry and the sequencer state encoding.
package conv_window_sequencer_pkg;

    localparam int ACC_ADDR_W = 8;
    typedef logic [ACC_ADDR_W-1:0] addr_t;

    localparam addr_t CTRL_BASE  = 8'h00;
    localparam addr_t COEFF_BASE = 8'h40;
    localparam addr_t DATA_BASE  = 8'h80;
    localparam addr_t RES_BASE   = 8'hC0;

    localparam logic [1:0] ROUTE_CTRL  = 2'd0;
    localparam logic [1:0] ROUTE_COEFF = 2'd1;
    localparam logic [1:0] ROUTE_DATA  = 2'd2;
    localparam logic [1:0] ROUTE_RES   = 2'd3;

    localparam int FILT_ROWS  = 3;
    localparam int FILT_COLS  = 3;
    localparam int NUM_COEFFS = FILT_ROWS * FILT_COLS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_addr_gen.sv
// Window counters (output row/col, filter row/col) and the coefficient, pixel
// and result addresses built from them.
module conv_addr_gen #(
    parameter int ADDR_W    = 8,
    parameter int FILT_ROWS = 3,
    parameter int FILT_COLS = 3,
    parameter int IMG_ROWS  = 8,
    parameter int IMG_COLS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_k,
    input  logic              step_pixel,
    input  logic              clear,
    output logic              last_k,
    output logic              last_pixel,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] res_addr
);
    import conv_window_sequencer_pkg::*;

    localparam int OFF_W    = ADDR_W - 2;
    localparam int OUT_ROWS = IMG_ROWS - FILT_ROWS + 1;
    localparam int OUT_COLS = IMG_COLS - FILT_COLS + 1;

    typedef logic [OFF_W-1:0] off_t;

    localparam off_t FR_LAST   = off_t'(FILT_ROWS - 1);
    localparam off_t FC_LAST   = off_t'(FILT_COLS - 1);
    localparam off_t OR_LAST   = off_t'(OUT_ROWS - 1);
    localparam off_t OC_LAST   = off_t'(OUT_COLS - 1);
    localparam off_t FILT_COLS_O = off_t'(FILT_COLS);
    localparam off_t IMG_COLS_O  = off_t'(IMG_COLS);
    localparam off_t OUT_COLS_O  = off_t'(OUT_COLS);

    off_t orow, ocol, fr, fc;
    off_t kOff, dataOff, resOff;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            orow <= '0;
            ocol <= '0;
            fr   <= '0;
            fc   <= '0;
        end else begin
            // fc runs fastest so that k = fr*FILT_COLS + fc counts up by one
            if (step_k) begin
                if (fc == FC_LAST) begin
                    fc <= '0;
                    fr <= (fr == FR_LAST) ? '0 : fr + off_t'(1);
                end else begin
                    fc <= fc + off_t'(1);
                end
            end
            if (step_pixel) begin
                if (ocol == OC_LAST) begin
                    ocol <= '0;
                    orow <= orow + off_t'(1);
                end else begin
                    ocol <= ocol + off_t'(1);
                end
            end
        end
    end

    assign last_k     = (fr == FR_LAST) && (fc == FC_LAST);
    assign last_pixel = (orow == OR_LAST) && (ocol == OC_LAST);

    // Offsets stay inside the 6-bit region field, so OR-ing the route on top never carries.
    assign kOff    = fr * FILT_COLS_O + fc;
    assign dataOff = (orow + fr) * IMG_COLS_O + (ocol + fc);
    assign resOff  = orow * OUT_COLS_O + ocol;

    assign coeff_addr = {ROUTE_COEFF, kOff};
    assign data_addr  = {ROUTE_DATA, dataOff};
    assign res_addr   = {ROUTE_RES, resOff};

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every valid 3x3 output pixel: issues coefficient/pixel reads, drives
// the MAC enable/clear pipeline and writes each accumulated result out.
module conv_window_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int FILT_ROWS = 3,
    parameter int FILT_COLS = 3,
    parameter int IMG_ROWS  = 8,
    parameter int IMG_COLS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic [ADDR_W-1:0] data_addr,
    output logic              mac_en,
    output logic              mac_clr,
    input  logic [DATA_W-1:0] mac_result,
    output logic              res_we,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbgState
);
    import conv_window_sequencer_pkg::*;

    seq_state_t        state, stateNext;
    logic              stepK, stepPixel, clearCnt, lastK, lastPixel;
    logic              issuing, writing, kIsZero;
    logic              macEnQ, kZeroQ;
    logic [DATA_W-1:0] wdataQ;
    logic [ADDR_W-1:0] coeffAddrGen, dataAddrGen, resAddrGen;

    conv_addr_gen #(
        .ADDR_W    (ADDR_W),
        .FILT_ROWS (FILT_ROWS),
        .FILT_COLS (FILT_COLS),
        .IMG_ROWS  (IMG_ROWS),
        .IMG_COLS  (IMG_COLS)
    ) uAddrGen (
        .clk        (clk),
        .reset      (reset),
        .step_k     (stepK),
        .step_pixel (stepPixel),
        .clear      (clearCnt),
        .last_k     (lastK),
        .last_pixel (lastPixel),
        .coeff_addr (coeffAddrGen),
        .data_addr  (dataAddrGen),
        .res_addr   (resAddrGen)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        stepK     = 1'b0;
        stepPixel = 1'b0;
        clearCnt  = 1'b0;
        case (state)
            IDLE:  if (start && !abort) stateNext = ISSUE;
            ISSUE: begin
                stepK = 1'b1;
                if (lastK) stateNext = DRAIN;
            end
            DRAIN: stateNext = WRITE;
            WRITE: if (res_ready) begin
                stepPixel = 1'b1;
                stateNext = lastPixel ? DONE : ISSUE;
            end
            DONE: begin
                clearCnt  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (abort && state != IDLE) begin
            stateNext = IDLE;
            stepK     = 1'b0;
            stepPixel = 1'b0;
            clearCnt  = 1'b1;
        end
    end

    assign issuing = (state == ISSUE);
    assign writing = (state == WRITE);
    assign kIsZero = (coeffAddrGen[ADDR_W-3:0] == '0);

    // Read data returns one cycle after rd_en, so the MAC strobes are rd_en delayed.
    always_ff @(posedge clk) begin
        if (reset) begin
            macEnQ <= 1'b0;
            kZeroQ <= 1'b0;
        end else begin
            macEnQ <= issuing && !abort;
            kZeroQ <= issuing && kIsZero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                      wdataQ <= '0;
        else if (state == DRAIN && stateNext == WRITE) wdataQ <= mac_result;
    end

    // Result handshake: res_we is the valid; res_addr/res_wdata are held with it
    // until res_ready, and the write transfers on the cycle both are high.
    assign res_we    = writing;
    assign res_addr  = writing ? resAddrGen : '0;
    assign res_wdata = writing ? wdataQ : '0;

    assign rd_en      = issuing;
    assign coeff_addr = issuing ? coeffAddrGen : '0;
    assign data_addr  = issuing ? dataAddrGen : '0;
    assign mac_en     = macEnQ;
    assign mac_clr    = macEnQ && kZeroQ;

    assign busy     = (state == ISSUE) || (state == DRAIN) || (state == WRITE);
    assign done     = (state == DONE);
    assign dbgState = state;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench for conv_window_sequencer with a queue-based reference model.
module tb_conv_window_sequencer;
    import conv_window_sequencer_pkg::*;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 8;
    localparam int IMG_ROWS = 8;
    localparam int IMG_COLS = 8;
    localparam int OUT_ROWS = IMG_ROWS - FILT_ROWS + 1;
    localparam int OUT_COLS = IMG_COLS - FILT_COLS + 1;

    logic              clk = 1'b0;
    logic              reset, start, abort, res_ready;
    logic [DATA_W-1:0] mac_result;
    logic              rd_en, mac_en, mac_clr, res_we, busy, done;
    logic [ADDR_W-1:0] coeff_addr, data_addr, res_addr;
    logic [DATA_W-1:0] res_wdata;
    logic [2:0]        dbgState;

    conv_window_sequencer #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .FILT_ROWS (FILT_ROWS),
        .FILT_COLS (FILT_COLS), .IMG_ROWS (IMG_ROWS), .IMG_COLS (IMG_COLS)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .rd_en (rd_en), .coeff_addr (coeff_addr), .data_addr (data_addr),
        .mac_en (mac_en), .mac_clr (mac_clr), .mac_result (mac_result),
        .res_we (res_we), .res_ready (res_ready), .res_addr (res_addr),
        .res_wdata (res_wdata), .busy (busy), .done (done), .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] expRdQ[$];
    logic [39:0] expWrQ[$];

    bit          chkEn = 0;
    int          cyc = 0;
    int          acceptCnt = 0, doneCnt = 0, rdCnt = 0;
    int          busyRiseCyc = -1, doneCyc = -1;
    int          stallPix = -1, stallLeft = 0;
    bit          holdLow = 0;
    bit          prevRd = 0, prevAbort = 0, prevHeld = 0, prevBusy = 0;
    logic [7:0]  prevCoeff = '0, prevResAddr = '0, lastResAddr = '0;
    logic [31:0] prevResData = '0;
    logic [7:0]  firstData[9];
    logic [7:0]  pinData[9] = '{8'h80, 8'h81, 8'h82, 8'h88, 8'h89, 8'h8A, 8'h90, 8'h91, 8'h92};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every window in raster order, coefficients k=0..8 per window.
    task automatic loadRun();
        expRdQ.delete();
        expWrQ.delete();
        for (int r = 0; r < OUT_ROWS; r++) begin
            for (int c = 0; c < OUT_COLS; c++) begin
                for (int fr = 0; fr < FILT_ROWS; fr++)
                    for (int fc = 0; fc < FILT_COLS; fc++)
                        expRdQ.push_back({COEFF_BASE | 8'(fr * FILT_COLS + fc),
                                          DATA_BASE | 8'((r + fr) * IMG_COLS + c + fc)});
                expWrQ.push_back({RES_BASE | 8'(r * OUT_COLS + c),
                                  32'h1234_0000 | 32'(r * OUT_COLS + c)});
            end
        end
        acceptCnt = 0; doneCnt = 0; rdCnt = 0;
        busyRiseCyc = -1; doneCyc = -1;
    endtask

    // MAC model and result-memory ready driver.
    initial begin
        res_ready = 1'b1;
        mac_result = '0;
        forever begin
            @(posedge clk); #1;
            mac_result = 32'h1234_0000 | 32'(acceptCnt);
            if (holdLow) res_ready = 1'b0;
            else if (res_we && acceptCnt == stallPix && stallLeft > 0) begin
                res_ready = 1'b0;
                stallLeft--;
            end else res_ready = 1'b1;
        end
    end

    // Compare process.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (chkEn) begin
            check("mac_en", mac_en, prevRd && !prevAbort);
            check("mac_clr", mac_clr, prevRd && !prevAbort && prevCoeff == COEFF_BASE);
            if (!busy && !done)
                check("idle_outputs", {rd_en, mac_en, mac_clr, res_we, coeff_addr, data_addr,
                                       res_addr, res_wdata}, 64'd0);
            if (rd_en) begin
                if (rdCnt < 9) firstData[rdCnt] = data_addr;
                rdCnt++;
                check("rd_expected", expRdQ.size() != 0, 1);
                if (expRdQ.size() != 0) begin
                    logic [15:0] e;
                    e = expRdQ.pop_front();
                    check("coeff_addr", coeff_addr, e[15:8]);
                    check("data_addr", data_addr, e[7:0]);
                end
            end
            if (res_we) begin
                check("rd_during_write", rd_en, 0);
                if (prevHeld) begin
                    check("held_res_addr", res_addr, prevResAddr);
                    check("held_res_wdata", res_wdata, prevResData);
                end
                if (res_ready) begin
                    check("wr_expected", expWrQ.size() != 0, 1);
                    if (expWrQ.size() != 0) begin
                        logic [39:0] w;
                        w = expWrQ.pop_front();
                        check("res_addr", res_addr, w[39:32]);
                        check("res_wdata", res_wdata, w[31:0]);
                    end
                    acceptCnt++;
                    lastResAddr = res_addr;
                end
            end
            if (busy && !prevBusy) busyRiseCyc = cyc;
            if (done) begin
                doneCnt++;
                doneCyc = cyc;
                check("busy_low_at_done", busy, 0);
            end
        end
        prevRd = rd_en; prevAbort = abort; prevCoeff = coeff_addr; prevBusy = busy;
        prevHeld = res_we && !res_ready; prevResAddr = res_addr; prevResData = res_wdata;
    end

    task automatic pulseStart();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic runFull(input int busyStartAt, input int stallAt, input int expLatency);
        int n;
        loadRun();
        stallPix = stallAt;
        stallLeft = 5;
        pulseStart();
        n = 0;
        while (doneCnt == 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
            start = (n == busyStartAt);
        end
        start = 1'b0;
        check("done_seen", doneCnt != 0, 1);
        check("latency", 64'(doneCyc - busyRiseCyc), 64'(expLatency));
        check("accept_count", acceptCnt, 36);
        check("last_res_addr", lastResAddr, 8'hE3);
        check("rd_queue_drained", expRdQ.size(), 0);
        check("wr_queue_drained", expWrQ.size(), 0);
        repeat (4) @(posedge clk);
        #1;
        check("done_once", doneCnt, 1);
        stallPix = -1;
    endtask

    task automatic checkAbortIdle(input string name);
        @(negedge clk);
        check(name, {busy, done, rd_en, res_we, mac_en, res_addr, data_addr}, 64'd0);
        expRdQ.delete();
        expWrQ.delete();
        repeat (10) @(posedge clk);
        #1;
        check({name, "_no_done"}, doneCnt, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {rd_en, mac_en, mac_clr, res_we, coeff_addr, data_addr,
                                res_addr, res_wdata}, 64'd0);
        check("reset_busy_done", {busy, done}, 0);
        check("reset_state", dbgState, 3'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chkEn = 1;

        // Plain run, ready always high.
        runFull(0, -1, 396);
        for (int i = 0; i < 9; i++) check($sformatf("first_data_%0d", i), firstData[i], pinData[i]);

        // Start while busy is ignored; this also proves a start after done restarts.
        runFull(50, -1, 396);

        // Five cycles of backpressure on pixel 7 (res_addr C7).
        runFull(0, 7, 401);

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", busy, 0);

        // Abort during ISSUE.
        loadRun();
        pulseStart();
        repeat (3) @(posedge clk);
        #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        checkAbortIdle("abort_issue");
        runFull(0, -1, 396);

        // Abort during WRITE with res_ready low.
        loadRun();
        holdLow = 1;
        pulseStart();
        n = 0;
        while (!res_we && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("write_reached", res_we, 1);
        @(posedge clk); #1; abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0; holdLow = 0;
        check("no_accept_while_low", acceptCnt, 0);
        checkAbortIdle("abort_write");
        runFull(0, -1, 396);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
